fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between instruction memory and the decode stage. Buffers up to DEPTH fetched {pc, instruction} pairs behind a valid/ready handshake on each side. Presents the head entry to decode together with the pre-sliced opcode, func3 and func7 fields that the decode controller consumes. Absorbs decode stalls and discards all buffered instructions on a pipeline flush (branch/jump redirect).

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- XLEN, 32, pc and instruction width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (redirect)
- in_valid  in  1  fetch side offers an entry
- in_ready  out  1  queue accepts an entry
- in_pc  in  XLEN  pc of the offered instruction
- in_inst  in  XLEN  offered instruction word
- out_valid  out  1  head entry valid toward decode
- out_ready  in  1  decode consumes the head entry
- out_pc  out  XLEN  head pc
- out_inst  out  XLEN  head instruction
- out_opcode  out  7  out_inst[6:0]
- out_func3  out  3  out_inst[14:12]
- out_func7  out  7  out_inst[31:25]
- count  out  $clog2(DEPTH)+1  current occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Storage is a circular buffer with write and read pointers of $clog2(DEPTH)+1 bits. The extra MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2*DEPTH. Indexing uses the low bits.
- push = in_valid && in_ready. The entry is written at the write pointer, which then increments.
- pop = out_valid && out_ready. The read pointer increments.
- in_ready = !full && !flush && !rst. A full queue does not accept an entry, even if a pop happens in the same cycle. This keeps in_ready free of any combinational path from out_ready.
- out_valid = !empty && !flush.
- While empty: out_inst = 32'h00000013 (NOP, addi x0,x0,0) and out_pc = 0. The field outputs are sliced from this NOP.
- Push and pop in the same cycle on a non-empty queue: count is unchanged and both pointers advance.
- flush is processed before push and pop. In the flush cycle no push and no pop occur. On the next edge both pointers clear to 0 and count becomes 0.
- Reset mid-operation: on the next edge all content is discarded, exactly like flush.
- Storage contents are not reset. Only the pointers are.

## Timing
- Reset values:
  - count 0, empty 1, full 0, out_valid 0.
  - out_inst 32'h00000013, out_pc 0.
  - in_ready 0 while rst is high, and 1 on the first cycle after rst deasserts.
- Latency without bypass: an entry pushed at edge N is visible on out_* (out_valid=1) after edge N, in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- out_* are driven combinationally from the storage entry at the read pointer, with no extra register stage.
- A flush asserted in cycle N:
  - forces out_valid=0 and in_ready=0 in cycle N;
  - leaves the queue empty in cycle N+1.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when the queue is empty, in_valid is high and flush is low:
  - out_valid = 1 and out_pc/out_inst = in_pc/in_inst in the same cycle;
  - if out_ready is also high, the entry is consumed directly and not written, so count stays 0;
  - if out_ready is low, the entry is written normally.
- FETCH_QUEUE_BYPASS_EN undefined: there is no combinational path from in_* to out_*, and latency is 1 cycle as stated under Timing.

## Structure
- The shared package holds:
  - NOP_INST = 32'h00000013;
  - field bounds for OPCODE (6:0), FUNC3 (14:12) and FUNC7 (31:25).
- The decode stage imports the same field constants.
- One sub-module, fetch_queue_mem: a DEPTH x 2*XLEN storage array with a synchronous write port and an asynchronous read port.
- Pointer, count and handshake logic stay in fetch_queue.

## Test plan
- Reset then idle → count=0, empty=1, out_valid=0, out_inst=32'h00000013, in_ready=1 in the first cycle after rst drops.
- Push 4 entries (pc 0x0,0x4,0x8,0xC; inst 0x00500093…) with out_ready=0 → full=1, in_ready=0, count=4. A 5th offer is not accepted.
- From full, assert out_ready for 4 cycles → pcs popped in order 0x0,0x4,0x8,0xC; out_opcode=7'h13 for 0x00500093; empty=1 afterwards.
- Steady push and pop every cycle for 20 cycles with pointer wrap → count stays constant and every pc appears exactly once, in order.
- Queue holds 3 entries; assert flush together with in_valid and out_ready → out_valid=0 and in_ready=0 that cycle, nothing is pushed, count=0 next cycle.
- With FETCH_QUEUE_BYPASS_EN, empty queue, in_valid=1, out_ready=1, in_pc=0x100 → out_valid=1 and out_pc=0x100 in the same cycle, count stays 0. Without the macro, out_valid rises one cycle later.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: NOP encoding and instruction field bounds shared by fetch and decode
package fetch_queue_pkg;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam int OPCODE_HI = 6;
  localparam int OPCODE_LO = 0;
  localparam int FUNC3_HI = 14;
  localparam int FUNC3_LO = 12;
  localparam int FUNC7_HI = 31;
  localparam int FUNC7_LO = 25;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x 2*XLEN storage with synchronous write and asynchronous read
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [2*XLEN-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [2*XLEN-1:0]        rdata
);
  logic [2*XLEN-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode instruction queue with flush; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  output logic [6:0]               out_opcode,
  output logic [2:0]               out_func3,
  output logic [6:0]               out_func7,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [2*XLEN-1:0] rdata;
  logic byp, push, pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign in_ready = !full && !flush && !rst;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty && in_valid && in_ready;
`else
  assign byp = 1'b0;
`endif
  assign out_valid = (!empty || byp) && !flush;
  assign pop = out_valid && out_ready && !empty;
  assign push = in_valid && in_ready && !(byp && out_ready);
  always_comb begin
    out_pc = !empty ? rdata[2*XLEN-1:XLEN] : byp ? in_pc : '0;
    out_inst = !empty ? rdata[XLEN-1:0] : byp ? in_inst : XLEN'(NOP_INST);
  end
  assign out_opcode = out_inst[OPCODE_HI:OPCODE_LO];
  assign out_func3 = out_inst[FUNC3_HI:FUNC3_LO];
  assign out_func7 = out_inst[FUNC7_HI:FUNC7_LO];
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  fetch_queue_mem #(.DEPTH(DEPTH), .XLEN(XLEN)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({in_pc, in_inst}),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic in_ready, out_valid, empty, full;
  logic [6:0] out_opcode, out_func7;
  logic [2:0] out_func3;
  logic [2:0] count;
  logic [63:0] q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] next_pc = 32'h0;
  always #5 clk = ~clk;
  fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .count(count), .empty(empty), .full(full)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, input bit f, input bit iv, input bit orr, input logic [31:0] pc, input logic [31:0] inst);
    int n;
    bit e_ready, e_valid, e_byp, e_push, e_pop;
    logic [31:0] e_pc, e_inst;
    rst = r; flush = f; in_valid = iv; out_ready = orr; in_pc = pc; in_inst = inst;
    #1;
    n = q.size();
    e_ready = (n < DEPTH) && !f && !r;
    e_byp = BYP && n == 0 && iv && e_ready;
    e_valid = (n > 0 || e_byp) && !f;
    e_pc = n > 0 ? q[0][63:32] : e_byp ? pc : 32'h0;
    e_inst = n > 0 ? q[0][31:0] : e_byp ? inst : 32'h00000013;
    e_push = iv && e_ready;
    e_pop = e_valid && orr;
    check("count", count, n);
    check("empty", empty, n == 0);
    check("full", full, n == DEPTH);
    check("in_ready", in_ready, e_ready);
    check("out_valid", out_valid, e_valid);
    check("out_pc", out_pc, e_pc);
    check("out_inst", out_inst, e_inst);
    check("out_opcode", out_opcode, e_inst[6:0]);
    check("out_func3", out_func3, e_inst[14:12]);
    check("out_func7", out_func7, e_inst[31:25]);
    @(posedge clk);
    if (r || f) q.delete();
    else if (!(e_byp && orr)) begin
      if (e_pop) void'(q.pop_front());
      if (e_push) q.push_back({pc, inst});
    end
    @(negedge clk);
  endtask
  task automatic offer(input bit orr);
    step(0, 0, 1, orr, next_pc, 32'h00500093 + (next_pc << 5));
    next_pc += 4;
  endtask
  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_pc = 0; in_inst = 0;
    @(posedge clk);
    @(negedge clk);
    step(1, 0, 1, 1, 32'h40, 32'h1);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) offer(0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) offer(1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) offer(0);
    step(0, 1, 1, 1, 32'h200, 32'h33);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h100, 32'h00a00113);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) offer(0);
    step(1, 0, 1, 1, 32'h300, 32'h13);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, next_pc, $urandom);
      next_pc += 4;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
